// File: rtl/bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= ADJ_THRESH) ? digit_i + ADJ_ADD : digit_i;

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Define BCD_BLANK_EN to replace leading zero digits with the blank code.
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [WIDTH-1:0]          bin_i,
    output logic                      busy_o,
    output logic                      valid_o,
    output logic [DIGITS*DIGIT_W-1:0] bcd_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SCR_W = DIGITS * DIGIT_W;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [WIDTH-1:0]     bin_q,   bin_d;
    logic [SCR_W-1:0]     scr_q,   scr_d;
    logic [SCR_W-1:0]     bcd_q,   bcd_d;
    logic                 valid_q, valid_d;

    logic [SCR_W-1:0]       scr_adj;
    logic [SCR_W+WIDTH-1:0] shift_v;
    logic [SCR_W-1:0]       bcd_fin;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scr_q[g*DIGIT_W +: DIGIT_W]),
            .digit_o (scr_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Binary MSB falls into bit 0 of the units digit; the top scratch bit drops out.
    assign shift_v = {scr_adj, bin_q} << 1;

`ifdef BCD_BLANK_EN
    logic lead;

    always_comb begin
        bcd_fin = shift_v[SCR_W+WIDTH-1:WIDTH];
        lead    = 1'b1;
        // Walk down from the top digit; the units digit is never blanked.
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (shift_v[WIDTH + i*DIGIT_W +: DIGIT_W] != '0) lead = 1'b0;
            if (lead) bcd_fin[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
        end
    end
`else
    assign bcd_fin = shift_v[SCR_W+WIDTH-1:WIDTH];
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    bin_d   = bin_i;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = shift_v[SCR_W+WIDTH-1:WIDTH];
                bin_d = shift_v[WIDTH-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = bcd_fin;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop take its value from the same pre-edge snapshot.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign valid_o = valid_q;
    assign bcd_o   = bcd_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Directed bench for bcd_converter: decimal reference model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_bcd_converter;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int BUSY_CYCLES = WIDTH + 1;

    logic                  clock_i;
    logic                  reset_i;
    logic                  start_i;
    logic [WIDTH-1:0]      bin_i;
    logic                  busy_o;
    logic                  valid_o;
    logic [DIGITS*4-1:0]   bcd_o;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    bcd_converter #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .start_i (start_i),
        .bin_i   (bin_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .bcd_o   (bcd_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Decimal expansion by division, with optional leading-digit blanking.
    function automatic logic [DIGITS*4-1:0] to_bcd(input int unsigned v);
        logic [DIGITS*4-1:0] r;
        int unsigned x;
        int msd;
        x   = v;
        msd = 0;
        r   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            if (x % 10 != 0) msd = i;
            x = x / 10;
        end
`ifdef BCD_BLANK_EN
        for (int i = 1; i < DIGITS; i++)
            if (i > msd) r[i*4 +: 4] = 4'hF;
`endif
        return r;
    endfunction

    // Reference timing: busy for WIDTH+1 cycles after an accept, valid in the last.
    int                  m_cnt;
    logic                m_valid;
    logic [DIGITS*4-1:0] m_bcd;
    logic [DIGITS*4-1:0] m_pending;

    always @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            m_cnt     <= 0;
            m_valid   <= 1'b0;
            m_bcd     <= '0;
            m_pending <= '0;
        end else if (m_cnt == 0) begin
            m_valid <= 1'b0;
            if (start_i) begin
                m_cnt     <= BUSY_CYCLES;
                m_pending <= to_bcd(int'(bin_i));
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                m_valid <= 1'b1;
                m_bcd   <= m_pending;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clock_i) begin
        if (cmp_en) begin
            check("busy_cycle",  64'(busy_o),  64'(m_cnt != 0));
            check("valid_cycle", 64'(valid_o), 64'(m_valid));
            check("bcd_cycle",   64'(bcd_o),   64'(m_bcd));
        end
    end

    task automatic run_conv(input int unsigned v, input int n_cyc,
                            output int valid_at, output int n_valid, output int n_busy);
        @(negedge clock_i);
        start_i  = 1'b1;
        bin_i    = WIDTH'(v);
        valid_at = -1;
        n_valid  = 0;
        n_busy   = 0;
        for (int k = 1; k <= n_cyc; k++) begin
            @(negedge clock_i);
            if (k == 1) start_i = 1'b0;
            if (busy_o) n_busy++;
            if (valid_o) begin
                n_valid++;
                if (valid_at < 0) valid_at = k;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int valid_at, n_valid, n_busy;
        int first_v, second_v;
        logic [DIGITS*4-1:0] exp_v;

        reset_i = 1'b1;
        start_i = 1'b0;
        bin_i   = '0;
        #1 reset_i = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clock_i);
        check("reset_busy",  64'(busy_o),  64'd0);
        check("reset_valid", 64'(valid_o), 64'd0);
        check("reset_bcd",   64'(bcd_o),   64'd0);
        reset_i = 1'b1;

`ifdef BCD_BLANK_EN
        check("model_0",     64'(to_bcd(0)),     64'hFFFF0);
        check("model_21",    64'(to_bcd(21)),    64'hFFF21);
        check("model_10500", 64'(to_bcd(10500)), 64'h10500);
`else
        check("model_0",     64'(to_bcd(0)),     64'h00000);
        check("model_21",    64'(to_bcd(21)),    64'h00021);
        check("model_10500", 64'(to_bcd(10500)), 64'h10500);
`endif
        check("model_65535", 64'(to_bcd(65535)), 64'h65535);

        // Zero: latency and busy duration.
        run_conv(0, 22, valid_at, n_valid, n_busy);
        check("zero_valid_at", 64'(valid_at), 64'd17);
        check("zero_n_valid",  64'(n_valid),  64'd1);
        check("zero_busy_len", 64'(n_busy),   64'd17);
`ifdef BCD_BLANK_EN
        check("zero_bcd", 64'(bcd_o), 64'hFFFF0);
`else
        check("zero_bcd", 64'(bcd_o), 64'h00000);
`endif

        run_conv(21, 20, valid_at, n_valid, n_busy);
        check("d21_valid_at", 64'(valid_at), 64'd17);
`ifdef BCD_BLANK_EN
        check("d21_bcd", 64'(bcd_o), 64'hFFF21);
`else
        check("d21_bcd", 64'(bcd_o), 64'h00021);
`endif

        run_conv(65535, 20, valid_at, n_valid, n_busy);
        check("max_valid_at", 64'(valid_at), 64'd17);
        check("max_bcd",      64'(bcd_o),    64'h65535);

        // Start request during SHIFT must be ignored.
        @(negedge clock_i);
        start_i = 1'b1;
        bin_i   = WIDTH'(1234);
        n_valid = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clock_i);
            start_i = (k == 5);
            if (k == 5) bin_i = WIDTH'(9999);
            if (valid_o) n_valid++;
        end
        check("ign_n_valid", 64'(n_valid), 64'd1);
`ifdef BCD_BLANK_EN
        check("ign_bcd", 64'(bcd_o), 64'hF1234);
`else
        check("ign_bcd", 64'(bcd_o), 64'h01234);
`endif

        // Reset in the middle of a conversion discards it.
        @(negedge clock_i);
        start_i = 1'b1;
        bin_i   = WIDTH'(500);
        n_valid = 0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clock_i);
            start_i = 1'b0;
            if (k == 8) begin
                #2 reset_i = 1'b0;
                #1;
                check("mid_rst_bcd",  64'(bcd_o),  64'd0);
                check("mid_rst_busy", 64'(busy_o), 64'd0);
            end
            if (k == 10) #2 reset_i = 1'b1;
            if (valid_o) n_valid++;
        end
        check("rst_no_valid", 64'(n_valid), 64'd0);
        check("rst_bcd_held", 64'(bcd_o),   64'd0);

        run_conv(7, 20, valid_at, n_valid, n_busy);
        check("d7_valid_at", 64'(valid_at), 64'd17);
`ifdef BCD_BLANK_EN
        check("d7_bcd", 64'(bcd_o), 64'hFFFF7);
`else
        check("d7_bcd", 64'(bcd_o), 64'h00007);
`endif

        // Level-held start: edges E..E+35 see it high, so exactly two accepts.
`ifdef BCD_BLANK_EN
        exp_v = 20'hFFF42;
`else
        exp_v = 20'h00042;
`endif
        @(negedge clock_i);
        start_i  = 1'b1;
        bin_i    = WIDTH'(42);
        n_valid  = 0;
        first_v  = -1;
        second_v = -1;
        for (int k = 1; k <= 56; k++) begin
            @(negedge clock_i);
            if (k == 36) start_i = 1'b0;
            if (valid_o) begin
                n_valid++;
                if (first_v < 0) first_v = k;
                else if (second_v < 0) second_v = k;
                check("held_bcd", 64'(bcd_o), 64'(exp_v));
            end
        end
        check("held_n_valid", 64'(n_valid),  64'd2);
        check("held_first",   64'(first_v),  64'd17);
        check("held_spacing", 64'(second_v - first_v), 64'd18);

        @(negedge clock_i);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
